// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with fill level, almost-full/almost-empty
// thresholds, optional first-word-fall-through read and sticky error flags.
// Ports: clk, rst_n (async, active low)
//   wr_en, wr_data         push side
//   rd_en, rd_data, rd_valid pop side (rd_en pops the head in FWFT mode)
//   full, empty, almost_full, almost_empty, level  status from registered level
//   overflow, underflow    sticky errors, cleared by clr_err at a clock edge
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_SIZE  = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTR_SIZE:0]   level,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam logic [PTR_SIZE:0] LVL_MAX =
    (PTR_SIZE+1)'(DEPTH);
  localparam logic [PTR_SIZE:0] LVL_AF =
    (PTR_SIZE+1)'(AFULL_TH);
  localparam logic [PTR_SIZE:0] LVL_AE =
    (PTR_SIZE+1)'(AEMPTY_TH);
  localparam logic [PTR_SIZE:0] LVL_ONE =
    (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE-1:0] PTR_ONE =
    PTR_SIZE'(1);

  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]   level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_acc, rd_acc;

  assign full         = (level_q == LVL_MAX);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Accepts use the pre-edge flags, so a full FIFO with both
  // requests pops but drops the write (and vice versa when empty).
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // A new error outranks a clear in the same cycle.
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && full)  ovf_d = 1'b1;
    if (rd_en && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while empty so the
    // output never carries uninitialised storage.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: checks a standard-read and an FWFT instance of
// fifo_sync_param against vector tables and a queue-based model.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] rd_data0, rd_data1;
  logic       rv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic       rv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] lvl0, lvl1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .WIDTH(8), .DEPTH(16), .PTR_SIZE(4),
    .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rv0),
    .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0),
    .level(lvl0), .overflow(ovf0), .underflow(unf0),
    .clr_err(clr_err)
  );

  fifo_sync_param #(
    .WIDTH(8), .DEPTH(16), .PTR_SIZE(4),
    .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rv1),
    .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1),
    .level(lvl1), .overflow(ovf1), .underflow(unf1),
    .clr_err(clr_err)
  );

  // Reference model: contents as a queue, plus the standard-mode
  // output register and the sticky error bits.
  logic [7:0] mq[$];
  logic [7:0] m_rdata;
  logic       m_rvalid;
  logic       m_ovf, m_unf;

  task automatic mdl_reset();
    mq.delete();
    m_rdata  = 8'h00;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic mdl_edge();
    bit was_full, was_empty;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    m_rvalid  = 1'b0;
    if (rd_en && !was_empty) begin
      m_rdata  = mq.pop_front();
      m_rvalid = 1'b1;
    end
    if (wr_en && !was_full) mq.push_back(wr_data);
    if (clr_err) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (wr_en && was_full)  m_ovf = 1'b1;
    if (rd_en && was_empty) m_unf = 1'b1;
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step(logic w, logic r, logic c,
                      logic [7:0] d);
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    wr_data = d;
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic chk_model(string tag);
    int n;
    n = mq.size();
    chk({tag, "_lvl0"}, 32'(lvl0), n);
    chk({tag, "_lvl1"}, 32'(lvl1), n);
    chk({tag, "_full0"}, 32'(full0), 32'(n == 16));
    chk({tag, "_empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, "_af0"}, 32'(af0), 32'(n >= 14));
    chk({tag, "_ae0"}, 32'(ae0), 32'(n <= 2));
    chk({tag, "_full1"}, 32'(full1), 32'(n == 16));
    chk({tag, "_empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, "_ovf0"}, 32'(ovf0), 32'(m_ovf));
    chk({tag, "_unf0"}, 32'(unf0), 32'(m_unf));
    chk({tag, "_ovf1"}, 32'(ovf1), 32'(m_ovf));
    chk({tag, "_unf1"}, 32'(unf1), 32'(m_unf));
    chk({tag, "_rv0"}, 32'(rv0), 32'(m_rvalid));
    chk({tag, "_rd0"}, 32'(rd_data0), 32'(m_rdata));
    chk({tag, "_rv1"}, 32'(rv1), 32'(n != 0));
    if (n != 0) chk({tag, "_rd1"}, 32'(rd_data1), 32'(mq[0]));
  endtask

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    int         lvl;
    logic       rv;
    logic [7:0] rdat;
    logic       ovf, unf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic w, logic r, logic c,
                              logic [7:0] d, int l,
                              logic v, logic [7:0] q,
                              logic o, logic u);
    vec_t e;
    e.wr = w; e.rd = r; e.clr = c; e.din = d;
    e.lvl = l; e.rv = v; e.rdat = q;
    e.ovf = o; e.unf = u;
    vt.push_back(e);
  endfunction

  initial begin
    // Fill 0x00..0x0F, drain, underflow, refill 0x10..0x1F,
    // write+read at full, clear, drain, write+read at empty.
    for (int i = 0; i < 16; i++)
      add(1, 0, 0, 8'(i), i + 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 0, 8'h00, 15 - i, 1, 8'(i), 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h0F, 0, 1);
    for (int i = 0; i < 16; i++)
      add(1, 0, 0, 8'(8'h10 + i), i + 1, 0, 8'h0F, 0, 1);
    add(1, 1, 0, 8'hAA, 15, 1, 8'h10, 1, 1);
    add(0, 0, 1, 8'h00, 15, 0, 8'h10, 0, 0);
    for (int i = 0; i < 15; i++)
      add(0, 1, 0, 8'h00, 14 - i, 1, 8'(8'h11 + i), 0, 0);
    add(1, 1, 0, 8'h33, 1, 0, 8'h1F, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 8'h33, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 8'h33, 0, 0);

    mdl_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lvl", 32'(lvl0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_ae", 32'(ae0), 1);
    chk("rst_af", 32'(af0), 0);
    chk("rst_rv0", 32'(rv0), 0);
    chk("rst_rd0", 32'(rd_data0), 0);
    chk("rst_rv1", 32'(rv1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].wr, vt[i].rd, vt[i].clr, vt[i].din);
      chk("vec_lvl", 32'(lvl0), vt[i].lvl);
      chk("vec_full", 32'(full0), 32'(vt[i].lvl == 16));
      chk("vec_empty", 32'(empty0), 32'(vt[i].lvl == 0));
      chk("vec_af", 32'(af0), 32'(vt[i].lvl >= 14));
      chk("vec_ae", 32'(ae0), 32'(vt[i].lvl <= 2));
      chk("vec_rv", 32'(rv0), 32'(vt[i].rv));
      chk("vec_rd", 32'(rd_data0), 32'(vt[i].rdat));
      chk("vec_ovf", 32'(ovf0), 32'(vt[i].ovf));
      chk("vec_unf", 32'(unf0), 32'(vt[i].unf));
      chk_model("vecm");
    end

    // Wrap: hold level 5 under 40 cycles of write+read.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 8'($urandom));
      chk_model("wrap_fill");
    end
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 8'($urandom));
      chk("wrap_lvl", 32'(lvl0), 5);
      chk_model("wrap");
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h00);
      chk_model("wrap_drain");
    end

    // FWFT: write into empty shows next cycle; pop empties it.
    step(1, 0, 0, 8'h5A);
    chk("fwft_rv", 32'(rv1), 1);
    chk("fwft_data", 32'(rd_data1), 32'h5A);
    step(0, 1, 0, 8'h00);
    chk("fwft_pop_rv", 32'(rv1), 0);
    chk("fwft_pop_empty", 32'(empty1), 1);
    chk("std_pop_data", 32'(rd_data0), 32'h5A);
    chk_model("fwft");

    // Async reset mid-burst at level 9 with underflow pending.
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 8'(8'h60 + i));
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("pre_rst_lvl", 32'(lvl0), 9);
    chk("pre_rst_unf", 32'(unf0), 1);
    @(posedge clk);
    mdl_edge();
    #3;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("arst_lvl0", 32'(lvl0), 0);
    chk("arst_lvl1", 32'(lvl1), 0);
    chk("arst_empty", 32'(empty0), 1);
    chk("arst_full", 32'(full0), 0);
    chk("arst_ae", 32'(ae0), 1);
    chk("arst_af", 32'(af0), 0);
    chk("arst_rv0", 32'(rv0), 0);
    chk("arst_rd0", 32'(rd_data0), 0);
    chk("arst_unf", 32'(unf0), 0);
    chk("arst_ovf", 32'(ovf0), 0);
    chk("arst_rv1", 32'(rv1), 0);
    chk("arst_rd1", 32'(rd_data1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 8'hC3);
    chk("post_rst_rd1", 32'(rd_data1), 32'hC3);
    step(0, 1, 0, 8'h00);
    chk("post_rst_rd0", 32'(rd_data0), 32'hC3);
    chk("post_rst_rv0", 32'(rv0), 1);
    chk_model("post_rst");

    // Random traffic, write-heavy then read-heavy.
    for (int i = 0; i < 400; i++) begin
      int wp;
      int rp;
      wp = (i < 200) ? 70 : 30;
      rp = (i < 200) ? 30 : 70;
      step(($urandom % 100) < wp, ($urandom % 100) < rp,
           ($urandom % 100) < 5, 8'($urandom));
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, next generation of the controller's FIFO family. Used for same-domain buffering in the SDRAM controller, e.g. command queue and write-data staging ahead of the bank FSM.
Generalises width and depth and adds the following over the dual-clock version:
- fill-level output
- programmable almost-full / almost-empty thresholds
- first-word-fall-through (FWFT) read mode
- sticky overflow / underflow error flags

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
PTR_SIZE, 4, log2(DEPTH); address bits of the storage array
AFULL_TH, 14, almost_full asserts when level >= AFULL_TH; legal range 1..DEPTH
AEMPTY_TH, 2, almost_empty asserts when level <= AEMPTY_TH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
wr_data  input  WIDTH  write data
rd_en  input  1  read request (pop in FWFT mode)
rd_data  output  WIDTH  read data
rd_valid  output  1  rd_data qualifier
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AFULL_TH
almost_empty  output  1  level <= AEMPTY_TH
level  output  PTR_SIZE+1  current entry count, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, asynchronous), applied immediately regardless of clk:
  - wr_ptr, rd_ptr, level cleared to 0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - rd_data=0, rd_valid=0, overflow=0, underflow=0
  - Storage array is not reset; reset mid-operation discards all contents.
- Accept rules:
  - Write accepted iff wr_en && !full.
  - Read accepted iff rd_en && !empty.
  - Evaluated against flag values from before the edge.
- Pointers: PTR_SIZE bits, incremented by 1 per accepted op, wrap DEPTH-1 -> 0 naturally.
- level (registered):
  - +1 on write-only, -1 on read-only.
  - Unchanged when both are accepted in the same cycle.
  - Never leaves 0..DEPTH.
- Flags: all flags are derived combinationally from registered level. They change in the cycle after the edge that accepted the op.
- Simultaneous events:
  - Full, wr_en=1, rd_en=1: read accepted, write rejected, overflow set, level -> DEPTH-1.
  - Empty, wr_en=1, rd_en=1: write accepted, read rejected, underflow set, level -> 1. There is no bypass in either mode.
- Standard mode (FWFT=0):
  - Accepted read registers mem[rd_ptr] into rd_data at that edge.
  - rd_valid=1 for exactly the following cycle, one pulse per accepted read.
  - rd_data holds its last value when no read is accepted; it is never driven to Z/X.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] (head word), rd_valid = !empty.
  - rd_en with rd_valid=1 pops the head; the next word appears the cycle after the pop.
  - A write into an empty FIFO is visible on rd_data with rd_valid=1 in the cycle after the write edge.
  - rd_data is don't-care while rd_valid=0.
- Storage write: mem[wr_ptr] <= wr_data on an accepted write; no other storage updates.
- Error flags:
  - overflow set on wr_en && full; underflow set on rd_en && empty.
  - Both are sticky until clr_err=1 at a clock edge.
  - If a new error and clr_err occur in the same cycle, set wins.
  - Rejected ops change no pointer, level, or data.

Test Plan:
1. Reset, then 16 writes 0x00..0x0F (DEPTH=16) -> level 0..16; full=1 after 16th edge; almost_full=1 from level 14; almost_empty=0 from level 3.
2. FWFT=0, read 16 -> rd_valid pulses one cycle after each rd_en, data 0x00..0x0F in order; empty=1 after last read; extra rd_en -> underflow=1, rd_data stays 0x0F.
3. Full FIFO, wr_en+rd_en together with wr_data=0xAA -> 0xAA discarded, overflow=1, level=15; clr_err -> overflow=0 next cycle.
4. Wrap: 40 cycles of continuous wr_en+rd_en at level 5 -> level constant 5; output sequence matches input sequence, with pointers wrapping twice.
5. FWFT=1, write 0x5A into empty -> next cycle rd_valid=1, rd_data=0x5A; pop with rd_en -> rd_valid=0, empty=1.
6. Assert rst_n low mid-burst at level 9, between clock edges -> all outputs reach reset values immediately without a clk edge; after release, first write/read returns the new data, not old contents.
